// File: rtl/pe_seq_pkg.sv
// Shared types for the PE sequencer: host config word, fetch-stage control
// word, FSM state encoding and a small width helper.
package pe_seq_pkg;

  // Default field widths; the port structs below are sized by these.
  localparam int SEQ_TAPW    = 4;
  localparam int SEQ_CHW     = 8;
  localparam int SEQ_OUTW    = 10;
  localparam int SEQ_MAXINFL = 8;

  // Layer configuration as presented by the host. Counts are stored minus one.
  typedef struct packed {
    logic [SEQ_TAPW-1:0] ntap_m1;
    logic [SEQ_CHW-1:0]  nch_m1;
    logic [SEQ_OUTW-1:0] nout_m1;
  } SeqCfg;

  // One beat to the fetch stage, tagged with psum clear/last.
  typedef struct packed {
    logic                psum_clr;
    logic                psum_last;
    logic [SEQ_TAPW-1:0] tap;
    logic [SEQ_CHW-1:0]  ch;
    logic [SEQ_OUTW-1:0] out;
  } SeqCtl;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_e;

  // Bits needed for a counter holding 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pe_seq_ctl_cnt3.sv
// Cascaded tap/channel/output loop counter. tap is the innermost level; each
// level wraps to zero at its programmed maximum and carries into the next.
// The wrap flags are combinational compares against the current value, so the
// parent can tell whether the beat currently held is the end of a level.
module seq_cnt3
  import pe_seq_pkg::*;
#(
  parameter int TAPW = SEQ_TAPW,
  parameter int CHW  = SEQ_CHW,
  parameter int OUTW = SEQ_OUTW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            inc,
  input  logic [TAPW-1:0] tap_max,
  input  logic [CHW-1:0]  ch_max,
  input  logic [OUTW-1:0] out_max,
  output logic [TAPW-1:0] tap,
  output logic [CHW-1:0]  ch,
  output logic [OUTW-1:0] out,
  output logic            tap_wrap,
  output logic            ch_wrap,
  output logic            out_wrap
);

  assign tap_wrap = (tap == tap_max);
  assign ch_wrap  = (ch == ch_max);
  assign out_wrap = (out == out_max);

  // Advance the loop nest by one beat; clear restarts it at (0,0,0).
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so each level decides its carry from the
    // pre-edge values of the levels below it, independent of statement order.
    if (rst || clr) begin
      tap <= '0;
      ch  <= '0;
      out <= '0;
    end else if (inc) begin
      if (tap_wrap) begin
        tap <= '0;
        if (ch_wrap) begin
          ch  <= '0;
          out <= out_wrap ? '0 : out + 1'b1;
        end else begin
          ch <= ch + 1'b1;
        end
      end else begin
        tap <= tap + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pe_seq_ctl.sv
// PE pipeline sequencer. Accepts one layer config from the host, walks the
// tap/channel/output loop nest issuing one control word per beat to the fetch
// stage, throttles last beats while the in-flight psum budget is exhausted,
// then drains until the sum stage has retired every psum and pulses o_done.
//
// ctl_rdy and o_ctl are decoded from registered state only (FSM state, loop
// counters, in-flight count), so a beat appears the cycle after the previous
// ack and nothing downstream sees a combinational path from any input.
module pe_seq_ctl
  import pe_seq_pkg::*;
#(
  // Field widths size the port structs and must match the package defaults.
  parameter int TAPW    = SEQ_TAPW,
  parameter int CHW     = SEQ_CHW,
  parameter int OUTW    = SEQ_OUTW,
  // Max psums whose last beat has been issued but not yet retired.
  parameter int MAXINFL = SEQ_MAXINFL
) (
  input  logic  i_clk,
  input  logic  i_rst,
  input  logic  cfg_rdy,
  output logic  cfg_ack,
  input  SeqCfg i_cfg,
  output logic  ctl_rdy,
  input  logic  ctl_ack,
  output SeqCtl o_ctl,
  input  logic  ret_rdy,
  output logic  ret_ack,
  input  logic  i_abort,
  output logic  o_busy,
  output logic  o_done,
  output logic  o_err
);

  localparam int            IW       = cnt_width(MAXINFL);
  localparam logic [IW-1:0] INFL_MAX = IW'(MAXINFL);

  // FSM and bookkeeping registers
  seq_state_e    state, state_nxt;
  SeqCfg         cfg_q;
  logic          abort_pend, abort_pend_nxt;
  logic [IW-1:0] inflight, inflight_nxt;
  logic          err_q, err_nxt;
  logic          cfg_ack_q;
  logic          ret_ack_q;
  logic          done_q;

  // Loop counter interface
  logic [TAPW-1:0] tap;
  logic [CHW-1:0]  ch;
  logic [OUTW-1:0] out;
  logic            tap_wrap, ch_wrap, out_wrap;
  logic            cnt_clr, cnt_inc;

  // Decoded conditions
  logic cfg_xfer, ctl_xfer, ret_xfer;
  logic beat_clr, beat_last, beat_final;
  logic infl_full, infl_inc;
  logic abort_eff;

  seq_cnt3 #(
    .TAPW (TAPW),
    .CHW  (CHW),
    .OUTW (OUTW)
  ) u_cnt (
    .clk      (i_clk),
    .rst      (i_rst),
    .clr      (cnt_clr),
    .inc      (cnt_inc),
    .tap_max  (cfg_q.ntap_m1),
    .ch_max   (cfg_q.nch_m1),
    .out_max  (cfg_q.nout_m1),
    .tap      (tap),
    .ch       (ch),
    .out      (out),
    .tap_wrap (tap_wrap),
    .ch_wrap  (ch_wrap),
    .out_wrap (out_wrap)
  );

  // The counters always hold the beat that is presented (or waiting) in RUN.
  assign beat_clr   = (tap == '0) && (ch == '0);
  assign beat_last  = tap_wrap & ch_wrap;
  assign beat_final = beat_last & out_wrap;
  assign infl_full  = (inflight == INFL_MAX);

  // Only a last beat is held back, and only while the psum budget is spent.
  assign ctl_rdy = (state == ST_RUN) && !(beat_last && infl_full);

  // cfg_ack_q is high only in IDLE, so a cfg transfer implies IDLE.
  assign cfg_xfer  = cfg_rdy & cfg_ack_q;
  assign ctl_xfer  = ctl_rdy & ctl_ack;
  assign ret_xfer  = ret_rdy & ret_ack_q;
  assign infl_inc  = ctl_xfer & beat_last;
  // A pulse seen in the same cycle as an ack already stops the next beat.
  assign abort_eff = abort_pend | i_abort;

  assign cfg_ack = cfg_ack_q;
  assign ret_ack = ret_ack_q;
  assign o_busy  = (state != ST_IDLE);
  assign o_done  = done_q;
  assign o_err   = err_q;

  // Control word to the fetch stage; forced to zero when no beat is offered.
  always_comb begin
    // NOTE: every signal written here is given a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    o_ctl = '0;
    if (ctl_rdy) begin
      o_ctl.psum_clr  = beat_clr;
      o_ctl.psum_last = beat_last;
      o_ctl.tap       = tap;
      o_ctl.ch        = ch;
      o_ctl.out       = out;
    end
  end

  // Next state, counter control and abort bookkeeping.
  always_comb begin
    state_nxt      = state;
    abort_pend_nxt = 1'b0;
    cnt_clr        = 1'b0;
    cnt_inc        = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (cfg_xfer) begin
          cnt_clr   = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (ctl_xfer) begin
          // The acked beat was the final one, or an abort is pending: stop.
          if (beat_final || abort_eff) begin
            state_nxt = ST_DRAIN;
          end else begin
            cnt_inc = 1'b1;
          end
        end else if (!ctl_rdy && abort_eff) begin
          // Throttled: nothing is on the bus, so an abort can leave at once.
          state_nxt = ST_DRAIN;
        end
        abort_pend_nxt = abort_eff && (state_nxt == ST_RUN);
      end
      ST_DRAIN: begin
        if (inflight == '0) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // In-flight psum count and the sticky retire-underflow error.
  always_comb begin
    inflight_nxt = inflight;
    err_nxt      = err_q;
    if (infl_inc && !ret_xfer) begin
      inflight_nxt = inflight + 1'b1;
    end else if (ret_xfer && !infl_inc) begin
      if (inflight == '0) begin
        err_nxt = 1'b1;
      end else begin
        inflight_nxt = inflight - 1'b1;
      end
    end
    // A new job starts from a clean slate.
    if (cfg_xfer) begin
      inflight_nxt = '0;
      err_nxt      = 1'b0;
    end
  end

  // State register; every output flop is forced low while i_rst is high.
  always_ff @(posedge i_clk) begin
    // NOTE: i_rst is sampled on the clock edge like any other input; it is
    // deliberately absent from the sensitivity list.
    if (i_rst) begin
      state      <= ST_IDLE;
      cfg_q      <= '0;
      abort_pend <= 1'b0;
      inflight   <= '0;
      err_q      <= 1'b0;
      cfg_ack_q  <= 1'b0;
      ret_ack_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      if (cfg_xfer) begin
        cfg_q <= i_cfg;
      end
      abort_pend <= abort_pend_nxt;
      inflight   <= inflight_nxt;
      err_q      <= err_nxt;
      cfg_ack_q  <= (state_nxt == ST_IDLE);
      ret_ack_q  <= 1'b1;
      done_q     <= (state == ST_DRAIN) && (state_nxt == ST_IDLE);
    end
  end

endmodule

// File: tb/tb_pe_seq_ctl.sv
// Self-checking bench for pe_seq_ctl. A cycle-level reference model built
// from the loop-nest rules (expected beat list in a queue, in-flight psum
// count, phase) predicts every output each cycle; directed scenarios cover
// throttling, abort, retire underflow and reset, then randomized jobs follow.
module tb_pe_seq_ctl;
  import pe_seq_pkg::*;

  localparam int TB_MAXINFL = 2;
  localparam int PH_IDLE  = 0;
  localparam int PH_RUN   = 1;
  localparam int PH_DRAIN = 2;

  logic  i_clk;
  logic  i_rst;
  logic  cfg_rdy;
  logic  cfg_ack;
  SeqCfg i_cfg;
  logic  ctl_rdy;
  logic  ctl_ack;
  SeqCtl o_ctl;
  logic  ret_rdy;
  logic  ret_ack;
  logic  i_abort;
  logic  o_busy;
  logic  o_done;
  logic  o_err;

  pe_seq_ctl #(
    .MAXINFL (TB_MAXINFL)
  ) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .cfg_rdy (cfg_rdy),
    .cfg_ack (cfg_ack),
    .i_cfg   (i_cfg),
    .ctl_rdy (ctl_rdy),
    .ctl_ack (ctl_ack),
    .o_ctl   (o_ctl),
    .ret_rdy (ret_rdy),
    .ret_ack (ret_ack),
    .i_abort (i_abort),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_err   (o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state
  int    m_phase;
  int    m_infl;
  logic  m_err;
  logic  m_done;
  logic  m_abort;
  SeqCtl beats[$];

  // Observation counters for per-scenario totals
  int obs_xfers;
  int obs_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected beat order for a config: tap innermost, then ch, then out.
  task automatic load_beats(input SeqCfg c);
    SeqCtl b;
    beats.delete();
    for (int o = 0; o <= int'(c.nout_m1); o++)
      for (int ch = 0; ch <= int'(c.nch_m1); ch++)
        for (int t = 0; t <= int'(c.ntap_m1); t++) begin
          b.psum_clr  = (t == 0) && (ch == 0);
          b.psum_last = (t == int'(c.ntap_m1)) && (ch == int'(c.nch_m1));
          b.tap       = SEQ_TAPW'(t);
          b.ch        = SEQ_CHW'(ch);
          b.out       = SEQ_OUTW'(o);
          beats.push_back(b);
        end
  endtask

  function automatic SeqCfg mk_cfg(input int nt, input int nc, input int no);
    SeqCfg c;
    c.ntap_m1 = SEQ_TAPW'(nt);
    c.nch_m1  = SEQ_CHW'(nc);
    c.nout_m1 = SEQ_OUTW'(no);
    return c;
  endfunction

  function automatic SeqCfg rand_cfg();
    return mk_cfg(int'($urandom_range(3)), int'($urandom_range(2)), int'($urandom_range(3)));
  endfunction

  // One clock cycle, entered and left at a negedge: check outputs against the
  // model, drive inputs, advance the model across the coming posedge.
  task automatic tick(input logic ack, input logic ret, input logic abort,
                      input logic cfgv, input SeqCfg c);
    SeqCtl head;
    logic  exp_rdy, ctl_x, inc, abort_eff, leave;
    int    infl0;
    head = '0;
    if (beats.size() > 0) head = beats[0];
    exp_rdy = (m_phase == PH_RUN) && (beats.size() > 0) &&
              !(head.psum_last && (m_infl == TB_MAXINFL));

    check("ctl_rdy", 32'(ctl_rdy), 32'(exp_rdy));
    if (exp_rdy) check("o_ctl", 32'(o_ctl), 32'(head));
    check("o_busy", 32'(o_busy), 32'(m_phase != PH_IDLE));
    check("o_done", 32'(o_done), 32'(m_done));
    check("o_err", 32'(o_err), 32'(m_err));
    check("cfg_ack", 32'(cfg_ack), 32'(m_phase == PH_IDLE));
    check("ret_ack", 32'(ret_ack), 32'(1));
    if (ctl_rdy && ack) obs_xfers++;
    if (o_done) obs_done++;

    ctl_ack = ack;
    ret_rdy = ret;
    i_abort = abort;
    cfg_rdy = cfgv;
    i_cfg   = c;

    infl0  = m_infl;
    ctl_x  = exp_rdy && ack;
    inc    = ctl_x && head.psum_last;
    m_done = 1'b0;
    if (inc && !ret) m_infl++;
    else if (ret && !inc) begin
      if (m_infl == 0) m_err = 1'b1;
      else m_infl--;
    end
    case (m_phase)
      PH_IDLE: if (cfgv) begin
        load_beats(c);
        m_phase = PH_RUN;
        m_err   = 1'b0;
        m_infl  = 0;
        m_abort = 1'b0;
      end
      PH_RUN: begin
        abort_eff = m_abort || abort;
        leave = 1'b0;
        if (ctl_x) begin
          void'(beats.pop_front());
          if (beats.size() == 0 || abort_eff) leave = 1'b1;
        end else if (!exp_rdy && abort_eff) leave = 1'b1;
        if (leave) begin
          m_phase = PH_DRAIN;
          m_abort = 1'b0;
          beats.delete();
        end else m_abort = abort_eff;
      end
      default: if (infl0 == 0) begin
        m_phase = PH_IDLE;
        m_done  = 1'b1;
      end
    endcase
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic start_job(input SeqCfg c);
    tick(1'b0, 1'b0, 1'b0, 1'b1, c);
    obs_xfers = 0;
    obs_done  = 0;
  endtask

  // Hold reset for one edge, check every output is low, then release.
  task automatic do_reset(input string tag);
    i_rst = 1'b1; cfg_rdy = 1'b0; ctl_ack = 1'b0; ret_rdy = 1'b0;
    i_abort = 1'b0; i_cfg = '0;
    @(posedge i_clk);
    @(negedge i_clk);
    check({tag, "_ctl_rdy"}, 32'(ctl_rdy), 32'(0));
    check({tag, "_o_ctl"}, 32'(o_ctl), 32'(0));
    check({tag, "_cfg_ack"}, 32'(cfg_ack), 32'(0));
    check({tag, "_ret_ack"}, 32'(ret_ack), 32'(0));
    check({tag, "_busy"}, 32'(o_busy), 32'(0));
    check({tag, "_done"}, 32'(o_done), 32'(0));
    check({tag, "_err"}, 32'(o_err), 32'(0));
    i_rst = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    m_phase = PH_IDLE; m_infl = 0; m_err = 1'b0; m_done = 1'b0; m_abort = 1'b0;
    beats.delete();
  endtask

  // Random traffic until the model returns to IDLE, bounded by a cycle budget.
  task automatic finish_job(input int ack_pct, input int ret_pct, input int abort_pm, input int budget);
    int n = 0;
    while (m_phase != PH_IDLE && n < budget) begin
      tick($urandom_range(99) < ack_pct,
           (m_infl > 0) && ($urandom_range(99) < ret_pct),
           $urandom_range(999) < abort_pm,
           1'($urandom_range(1)), rand_cfg());
      n++;
    end
    if (n >= budget) check("job_timeout", 32'(n), 32'(budget - 1));
    cfg_rdy = 1'b0; ctl_ack = 1'b0; ret_rdy = 1'b0; i_abort = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1;
    do_reset("rst0");
    idle_ticks(1);

    // 1: 3 taps x 2 ch x 1 out at full rate; config waits while busy.
    start_job(mk_cfg(2, 1, 0));
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, 1'b0, 1'b1, mk_cfg(1, 1, 1));
    check("t1_beats", 32'(obs_xfers), 32'(6));
    tick(1'b1, 1'b0, 1'b0, 1'b1, mk_cfg(1, 1, 1));
    tick(1'b1, 1'b0, 1'b0, 1'b0, '0);
    check("t1_drain_busy", 32'(o_busy), 32'(1));
    tick(1'b0, 1'b1, 1'b0, 1'b0, '0);
    idle_ticks(3);
    check("t1_done_pulses", 32'(obs_done), 32'(1));

    // 2: every beat is last; budget of 2 psums throttles the third.
    start_job(mk_cfg(0, 0, 3));
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, '0);
    check("t2_beats", 32'(obs_xfers), 32'(2));
    check("t2_throttled", 32'(ctl_rdy), 32'(0));
    tick(1'b0, 1'b1, 1'b0, 1'b0, '0);
    check("t2_release", 32'(ctl_rdy), 32'(1));
    finish_job(100, 50, 0, 300);
    idle_ticks(2);

    // 3: same nest as 1 under random backpressure.
    start_job(mk_cfg(2, 1, 0));
    finish_job(40, 50, 0, 500);
    idle_ticks(2);

    // 4: abort with a beat on the bus; it completes, then DRAIN waits.
    start_job(mk_cfg(0, 1, 3));
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, '0);
    tick(1'b0, 1'b0, 1'b1, 1'b0, '0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, '0);
    check("t4_beats", 32'(obs_xfers), 32'(4));
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b1, 1'b0, '0);
    check("t4_no_done_yet", 32'(obs_done), 32'(0));
    finish_job(50, 60, 0, 200);
    idle_ticks(2);
    check("t4_done_pulses", 32'(obs_done), 32'(1));

    // 5: retire with nothing in flight; count must stay at zero.
    tick(1'b0, 1'b1, 1'b0, 1'b0, '0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, '0);
    check("t5_err_set", 32'(o_err), 32'(1));
    start_job(mk_cfg(0, 0, 3));
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, '0);
    check("t5_beats", 32'(obs_xfers), 32'(2));
    finish_job(80, 50, 0, 300);
    idle_ticks(2);

    // 6: reset during RUN and during DRAIN, then a normal job.
    start_job(mk_cfg(1, 1, 2));
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, '0);
    do_reset("rst_run");
    idle_ticks(1);
    start_job(mk_cfg(0, 0, 1));
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, '0);
    check("t6_in_drain", 32'(o_busy), 32'(1));
    do_reset("rst_drain");
    idle_ticks(1);
    start_job(mk_cfg(1, 0, 1));
    finish_job(70, 50, 0, 300);
    idle_ticks(2);

    // Randomized jobs with occasional aborts.
    for (int j = 0; j < 10; j++) begin
      start_job(rand_cfg());
      finish_job(30 + int'($urandom_range(70)), 30 + int'($urandom_range(60)), 15, 2000);
      idle_ticks(2);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
